// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two valid/ready requesters, after a post-reset init pass that fills a RAM region.
// Define BRAM_ARB_FIXED_PRIO_EN to make req0 win every conflict instead of round-robin alternation.
module bram_port_arbiter #(
  parameter int unsigned          RAM_WIDTH  = 16,
  parameter int unsigned          ADDR_WIDTH = 9,
  parameter int unsigned          INIT_DEPTH = 16,
  parameter int unsigned          INIT_BASE  = 0,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [RAM_WIDTH-1:0]  req0_wdata,
  output logic                  rsp0_valid,
  output logic [RAM_WIDTH-1:0]  rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [RAM_WIDTH-1:0]  req1_wdata,
  output logic                  rsp1_valid,
  output logic [RAM_WIDTH-1:0]  rsp1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]  mem_din,
  input  logic [RAM_WIDTH-1:0]  mem_dout,
  output logic                  init_done
);

  typedef enum logic {ST_INIT, ST_ARB} state_t;

  localparam int unsigned CNT_W = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = (INIT_DEPTH > 0) ? CNT_W'(INIT_DEPTH - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(INIT_BASE);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
  logic [RAM_WIDTH-1:0]    din_hold_q, din_hold_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [RAM_WIDTH-1:0]    rdata0_q, rdata0_d;
  logic [RAM_WIDTH-1:0]    rdata1_q, rdata1_d;
  logic                    grant0, grant1;
`ifndef BRAM_ARB_FIXED_PRIO_EN
  logic                    last_q, last_d;
`endif

  // Grants are combinational so the RAM sees the address in the accept cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rstb && state_q == ST_ARB) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`else
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = '0;
    mem_we      = 1'b0;
    mem_addr    = addr_hold_q;
    mem_din     = din_hold_q;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (INIT_DEPTH == 0) begin
          state_d     = ST_ARB;
          init_done_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          mem_addr = BASE_ADDR + ADDR_WIDTH'(cnt_q);
          mem_din  = INIT_VALUE;
          if (cnt_q == LAST_CNT) begin
            state_d     = ST_ARB;
            init_done_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (grant0) begin
          mem_we         = req0_we;
          mem_addr       = req0_addr;
          mem_din        = req0_wdata;
          rsp_valid_d[0] = !req0_we;
`ifndef BRAM_ARB_FIXED_PRIO_EN
          last_d         = 1'b0;
`endif
        end else if (grant1) begin
          mem_we         = req1_we;
          mem_addr       = req1_addr;
          mem_din        = req1_wdata;
          rsp_valid_d[1] = !req1_we;
`ifndef BRAM_ARB_FIXED_PRIO_EN
          last_d         = 1'b1;
`endif
        end
      end
    endcase
    addr_hold_d = mem_addr;
    din_hold_d  = mem_din;
    if (rstb) begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
    end
    rsp0_valid = rsp_valid_q[0] && !rstb;
    rsp1_valid = rsp_valid_q[1] && !rstb;
    rsp0_rdata = rsp0_valid ? mem_dout : rdata0_q;
    rsp1_rdata = rsp1_valid ? mem_dout : rdata1_q;
    rdata0_d   = rsp0_rdata;
    rdata1_d   = rsp1_rdata;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign init_done  = init_done_q;

  // Pointer resets to req1 so that req0 wins the first tie.
  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
      rsp_valid_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
      rsp_valid_q <= rsp_valid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed literal checks plus randomized traffic against a transaction-level model.
// Extra instances cover the zero-depth and address-wrapping init passes.
module tb_bram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int INIT_DEPTH = 16;
  localparam int INIT_BASE = 0;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic          rstb;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          mem_we, init_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  logic          idle_v, idle_we;
  logic [AW-1:0] idle_addr;
  logic [DW-1:0] idle_data, idle_dout;

  logic          z_req0_ready, z_req1_ready, z_rsp0_valid, z_rsp1_valid, z_mem_we, z_init_done;
  logic [DW-1:0] z_rsp0_rdata, z_rsp1_rdata, z_mem_din;
  logic [AW-1:0] z_mem_addr;
  logic          w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_mem_we, w_init_done;
  logic [DW-1:0] w_rsp0_rdata, w_rsp1_rdata, w_mem_din;
  logic [AW-1:0] w_mem_addr;

  int checks = 0;
  int errors = 0;

  bram_port_arbiter dut (
    .clka(clka), .rstb(rstb),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .init_done(init_done)
  );

  bram_port_arbiter #(.INIT_DEPTH(0)) dut_z (
    .clka(clka), .rstb(rstb),
    .req0_valid(idle_v), .req0_ready(z_req0_ready), .req0_we(idle_we), .req0_addr(idle_addr),
    .req0_wdata(idle_data), .rsp0_valid(z_rsp0_valid), .rsp0_rdata(z_rsp0_rdata),
    .req1_valid(idle_v), .req1_ready(z_req1_ready), .req1_we(idle_we), .req1_addr(idle_addr),
    .req1_wdata(idle_data), .rsp1_valid(z_rsp1_valid), .rsp1_rdata(z_rsp1_rdata),
    .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_din(z_mem_din), .mem_dout(idle_dout),
    .init_done(z_init_done)
  );

  bram_port_arbiter #(.INIT_DEPTH(4), .INIT_BASE(510), .INIT_VALUE(16'h5A5A)) dut_w (
    .clka(clka), .rstb(rstb),
    .req0_valid(idle_v), .req0_ready(w_req0_ready), .req0_we(idle_we), .req0_addr(idle_addr),
    .req0_wdata(idle_data), .rsp0_valid(w_rsp0_valid), .rsp0_rdata(w_rsp0_rdata),
    .req1_valid(idle_v), .req1_ready(w_req1_ready), .req1_we(idle_we), .req1_addr(idle_addr),
    .req1_wdata(idle_data), .rsp1_valid(w_rsp1_valid), .rsp1_rdata(w_rsp1_rdata),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_din(w_mem_din), .mem_dout(idle_dout),
    .init_done(w_init_done)
  );

  // Write-first single-port RAM behind the main instance
  logic [DW-1:0] ram [0:511];
  always @(posedge clka) begin
    if (mem_we === 1'b1) ram[mem_addr] <= mem_din;
    mem_dout <= (mem_we === 1'b1) ? mem_din : ram[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(posedge clka);
    #1;
    rstb = rst;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic idleCycle(input logic rst);
    applyStimulus(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic newReq(output logic v, output logic we, output logic [AW-1:0] a, output logic [DW-1:0] d);
    v  = ($urandom_range(0, 9) < 6);
    we = ($urandom_range(0, 2) == 0);
    a  = AW'($urandom_range(32, 79));
    d  = DW'($urandom);
  endtask

  // Reference model: init progress, last winner, held port values, pending reads and a shadow memory.
  bit            m_known = 1'b0;
  bit            m_init, m_done, m_last;
  int            m_idx;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  bit            m_pend [2];
  logic [DW-1:0] m_pdata [2];
  logic [DW-1:0] m_hold [2];
  logic [DW-1:0] shadow [0:511];
  bit            eg0, eg1, ewe;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  always @(negedge clka) begin
    if (m_known) begin
      eg0 = 1'b0; eg1 = 1'b0; ewe = 1'b0; ea = m_addr; ed = m_din;
      if (rstb) begin
        ea = '0; ed = '0;
      end else if (m_init) begin
        if (INIT_DEPTH > 0) begin
          ewe = 1'b1;
          ea  = AW'((INIT_BASE + m_idx) % 512);
          ed  = '0;
        end
      end else begin
        if (req0_valid && req1_valid) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
          eg0 = 1'b1;
`else
          if (m_last) eg0 = 1'b1; else eg1 = 1'b1;
`endif
        end else begin
          eg0 = req0_valid;
          eg1 = req1_valid;
        end
        if (eg0) begin ewe = req0_we; ea = req0_addr; ed = req0_wdata; end
        if (eg1) begin ewe = req1_we; ea = req1_addr; ed = req1_wdata; end
      end
      checkOutput("m_req0_ready", req0_ready, eg0);
      checkOutput("m_req1_ready", req1_ready, eg1);
      checkOutput("m_mem_we", mem_we, ewe);
      checkOutput("m_mem_addr", mem_addr, ea);
      checkOutput("m_mem_din", mem_din, ed);
      checkOutput("m_init_done", init_done, m_done);
      checkOutput("m_rsp0_valid", rsp0_valid, m_pend[0] && !rstb);
      checkOutput("m_rsp1_valid", rsp1_valid, m_pend[1] && !rstb);
      checkOutput("m_rsp0_rdata", rsp0_rdata, (m_pend[0] && !rstb) ? m_pdata[0] : m_hold[0]);
      checkOutput("m_rsp1_rdata", rsp1_rdata, (m_pend[1] && !rstb) ? m_pdata[1] : m_hold[1]);
    end
    if (rstb === 1'b1) begin
      m_known = 1'b1; m_init = 1'b1; m_done = 1'b0; m_last = 1'b1; m_idx = 0;
      m_addr = '0; m_din = '0;
      for (int n = 0; n < 2; n++) begin m_pend[n] = 1'b0; m_hold[n] = '0; end
    end else if (m_known) begin
      for (int n = 0; n < 2; n++) begin
        if (m_pend[n]) m_hold[n] = m_pdata[n];
        m_pend[n] = 1'b0;
      end
      if (m_init) begin
        if (INIT_DEPTH > 0) begin
          shadow[ea] = ed; m_addr = ea; m_din = ed;
          m_idx++;
          if (m_idx == INIT_DEPTH) begin m_init = 1'b0; m_done = 1'b1; end
        end else begin
          m_init = 1'b0; m_done = 1'b1;
        end
      end else if (eg0 || eg1) begin
        m_last = eg1; m_addr = ea; m_din = ed;
        if (ewe) shadow[ea] = ed;
        else begin m_pend[eg1 ? 1 : 0] = 1'b1; m_pdata[eg1 ? 1 : 0] = shadow[ea]; end
      end
    end
  end

  task automatic checkRsp(input int n);
    checkOutput("arb_rsp0_valid", rsp0_valid, n == 0);
    checkOutput("arb_rsp1_valid", rsp1_valid, n == 1);
    if (n == 0) checkOutput("arb_rsp0_rdata", rsp0_rdata, 16'h1020);
    else        checkOutput("arb_rsp1_rdata", rsp1_rdata, 16'h1030);
  endtask

  initial begin
    int wrap_exp [4] = '{510, 511, 0, 1};
`ifdef BRAM_ARB_FIXED_PRIO_EN
    int exp_grant [5] = '{0, 0, 0, 0, 0};
`else
    int exp_grant [5] = '{0, 1, 0, 1, 0};
`endif
    bit acc0, acc1;
    idle_v = 1'b0; idle_we = 1'b0; idle_addr = '0; idle_data = '0; idle_dout = '0;
    rstb = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    for (int i = 0; i < 512; i++) begin
      ram[i] = DW'(16'h1000 + i);
      shadow[i] = DW'(16'h1000 + i);
    end
    repeat (3) idleCycle(1'b1);

    // Init pass with both requesters already waiting
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 9'h020, '0, 1'b1, 1'b0, 9'h030, '0);
      @(negedge clka);
      checkOutput("init_we", mem_we, 1);
      checkOutput("init_addr", mem_addr, i);
      checkOutput("init_din", mem_din, 0);
      checkOutput("init_ready0", req0_ready, 0);
      checkOutput("init_ready1", req1_ready, 0);
      checkOutput("init_done_low", init_done, 0);
      if (i < 4) begin
        checkOutput("wrap_we", w_mem_we, 1);
        checkOutput("wrap_addr", w_mem_addr, wrap_exp[i]);
        checkOutput("wrap_din", w_mem_din, 16'h5A5A);
        checkOutput("wrap_done_low", w_init_done, 0);
      end
      if (i == 4) begin
        checkOutput("wrap_done", w_init_done, 1);
        checkOutput("wrap_we_off", w_mem_we, 0);
      end
      if (i == 0) begin
        checkOutput("zero_we", z_mem_we, 0);
        checkOutput("zero_done_low", z_init_done, 0);
      end
      if (i == 1) checkOutput("zero_done", z_init_done, 1);
    end

    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 9'h020, '0, 1'b1, 1'b0, 9'h030, '0);
      @(negedge clka);
      checkOutput("arb_init_done", init_done, 1);
      checkOutput("arb_ready0", req0_ready, exp_grant[k] == 0);
      checkOutput("arb_ready1", req1_ready, exp_grant[k] == 1);
      if (k > 0) checkRsp(exp_grant[k-1]);
    end
    idleCycle(1'b0);
    @(negedge clka);
    checkRsp(exp_grant[4]);

    // Write then read the same address from the other requester
    applyStimulus(1'b0, 1'b1, 1'b1, 9'h040, 16'hBEEF, 1'b0, 1'b0, '0, '0);
    @(negedge clka);
    checkOutput("raw_ready0", req0_ready, 1);
    checkOutput("raw_we", mem_we, 1);
    checkOutput("raw_addr", mem_addr, 9'h040);
    checkOutput("raw_din", mem_din, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h040, '0);
    @(negedge clka);
    checkOutput("raw_ready1", req1_ready, 1);
    checkOutput("raw_rd_we", mem_we, 0);
    idleCycle(1'b0);
    @(negedge clka);
    checkOutput("raw_rsp1_valid", rsp1_valid, 1);
    checkOutput("raw_rsp1_rdata", rsp1_rdata, 16'hBEEF);
    idleCycle(1'b0);
    @(negedge clka);
    checkOutput("raw_rsp1_drop", rsp1_valid, 0);
    checkOutput("raw_rdata_hold", rsp1_rdata, 16'hBEEF);
    checkOutput("idle_we", mem_we, 0);
    checkOutput("idle_addr_hold", mem_addr, 9'h040);

    // Reset in the middle of the init pass, then right after an accepted read
    idleCycle(1'b1);
    for (int i = 0; i < 7; i++) idleCycle(1'b0);
    @(negedge clka);
    checkOutput("rst_pre_addr", mem_addr, 6);
    idleCycle(1'b1);
    @(negedge clka);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_addr", mem_addr, 0);
    idleCycle(1'b0);
    @(negedge clka);
    checkOutput("restart_we", mem_we, 1);
    checkOutput("restart_addr", mem_addr, INIT_BASE);
    checkOutput("restart_done", init_done, 0);
    for (int k = 0; k < 40 && init_done !== 1'b1; k++) begin
      idleCycle(1'b0);
      @(negedge clka);
    end
    checkOutput("init_done_wait", init_done, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h021, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clka);
    checkOutput("pre_rst_ready0", req0_ready, 1);
    idleCycle(1'b1);
    @(negedge clka);
    checkOutput("drop_rsp0_a", rsp0_valid, 0);
    idleCycle(1'b0);
    @(negedge clka);
    checkOutput("drop_rsp0_b", rsp0_valid, 0);
    checkOutput("drop_done", init_done, 0);
    checkOutput("drop_init_we", mem_we, 1);

    // Randomized traffic with cancellations and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clka);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clka);
      #1;
      if (rstb) rstb = ($urandom_range(0, 2) == 0);
      else      rstb = ($urandom_range(0, 299) == 0);
      if (req0_valid && !acc0) begin
        if ($urandom_range(0, 9) == 0) req0_valid = 1'b0;
      end else newReq(req0_valid, req0_we, req0_addr, req0_wdata);
      if (req1_valid && !acc1) begin
        if ($urandom_range(0, 9) == 0) req1_valid = 1'b0;
      end else newReq(req1_valid, req1_we, req1_addr, req1_wdata);
    end
    repeat (3) idleCycle(1'b0);
    @(negedge clka);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
